sram_h_cascading: RTL and testbench
===================================

SRAM_H_CASCADING -- requirements
Module: sram_h_cascading

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the total word width of the cascaded memory.
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width; depth = 2**ADDR_W (8 words).
REQ-003 Parameter SLICE_W, default 4, SHALL set the width of each horizontal slice; DATA_W SHALL be an integer multiple of SLICE_W.
REQ-004 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset, asynchronous, active-high.
- inp  input  DATA_W  write data.
- addr  input  ADDR_W  word address for read and write.
- we  input  1  write enable; 1 = write, 0 = read.
- cs  input  1  chip select; 0 = idle.
- outp  output  DATA_W  registered read data.
REQ-005 The ports after clk/rst SHALL keep the order inp, addr, we, cs, outp.

Function
REQ-006 Memory SHALL be DATA_W/SLICE_W slices of 2**ADDR_W x SLICE_W words; slice k SHALL store bits [k*SLICE_W +: SLICE_W]; all slices SHALL share addr, we, cs.
REQ-007 Write: on rising clk with cs=1 and we=1, each slice SHALL store its inp bits at addr; outp SHALL hold its value.
REQ-008 Read: on rising clk with cs=1 and we=0, each slice SHALL register its word at addr onto its outp bits; latency exactly 1 clock.
REQ-009 Idle: with cs=0, no memory word and no outp bit SHALL change, regardless of we, addr or inp.
REQ-010 outp SHALL be the concatenation of the slice outputs, with slice 0 in the LSBs and no reordering or bit loss.
REQ-011 A write followed by a read of the same address on the next edge SHALL return the new data; there is no write-through on the write cycle itself.
REQ-012 Every address 0..2**ADDR_W-1 SHALL be valid; addr never wraps or aliases.
REQ-013 Consecutive writes to the same address SHALL retain the last value only.

Reset
REQ-014 While rst=1, asynchronously and regardless of clk, all memory words in all slices SHALL clear to 0 and outp SHALL be 0.
REQ-015 rst asserted mid-operation SHALL abort any write on that edge; the first write or read SHALL take effect on the first rising clk after rst deasserts.
REQ-016 A read of any address after reset with no intervening write SHALL return 0.

Structure
REQ-017 DATA_W, ADDR_W and SLICE_W defaults and the derived slice count SHALL live in a shared package, sram_pkg.
REQ-018 One sub-module SHALL exist: sram_slice, a 2**ADDR_W x SLICE_W synchronous RAM with ports clk, rst, din, addr, we, cs, dout.
REQ-019 sram_h_cascading SHALL instantiate sram_slice DATA_W/SLICE_W times through a generate loop and contain no other storage.

Verification
REQ-020 Reset: pulse rst=1 between clk edges -> outp=0x00 immediately, and reads of addr 0..7 return 0x00.
REQ-021 Write/read sweep: cs=1, we=1, write addr 0..7 = 24,81,09,63,0D,8D,65,12 (hex), then we=0 and read 0..7 -> outp is the same sequence, each value one clock after its address.
REQ-022 Slice independence: write 0xF0 to addr 2 and 0x0F to addr 5 -> reading returns 0xF0 and 0x0F, so the upper and lower slices are not swapped.
REQ-023 Chip deselect: cs=0, we=1, inp=0xAA to addr 0 -> a later read of addr 0 still returns its previous value, and outp is unchanged while cs=0.
REQ-024 Overwrite: write 0x11 then 0x22 to addr 7 -> the read returns 0x22; write 0x33 to addr 3 then read addr 3 on the next edge -> 0x33.
REQ-025 Mid-operation reset: assert rst during a write sweep -> all words read back 0x00 and outp=0x00.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared sizing for the horizontally cascaded SRAM.
// Slice count is derived from the word and slice widths.
package sram_pkg;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_SLICE_W = 4;
  localparam int DEF_N_SLICE = DEF_DATA_W / DEF_SLICE_W;

  function automatic int n_slices(input int dw, input int sw);
    return dw / sw;
  endfunction
endpackage

// File: rtl/sram_h_cascading_if.sv
// Bus bundle for the cascaded SRAM: request side and read data.
// Master drives requests, slave returns registered read data.
interface sram_h_cascading_if
  import sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic [DATA_W-1:0] inp;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              cs;
  logic [DATA_W-1:0] outp;

  modport master (
    output inp, addr, we, cs,
    input  outp
  );
  modport slave (
    input  inp, addr, we, cs,
    output outp
  );
endinterface

// File: rtl/sram_slice.sv
// One narrow synchronous RAM slice with registered read data.
// Reset clears every word and the output register.
module sram_slice
  import sram_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SLICE_W-1:0] din,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               we,
  input  logic               cs,
  output logic [SLICE_W-1:0] dout
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [SLICE_W-1:0] mem_q [DEPTH];
  logic [SLICE_W-1:0] dout_q;
  logic [SLICE_W-1:0] dout_d;

  always_comb begin
    dout_d = dout_q;
    if (cs && !we) dout_d = mem_q[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dout_q <= '0;
    end else begin
      if (cs && we) mem_q[addr] <= din;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
endmodule

// File: rtl/sram_h_cascading.sv
// Wide SRAM built from identical narrow slices side by side.
// Slice k owns word bits [k*SLICE_W +: SLICE_W]; control is shared.
module sram_h_cascading
  import sram_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inp,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              cs,
  output logic [DATA_W-1:0] outp
);
  localparam int NS = n_slices(DATA_W, SLICE_W);

  for (genvar k = 0; k < NS; k++) begin : g_slice
    sram_slice #(
      .ADDR_W (ADDR_W),
      .SLICE_W(SLICE_W)
    ) u_slice (
      .clk (clk),
      .rst (rst),
      .din (inp[k*SLICE_W +: SLICE_W]),
      .addr(addr),
      .we  (we),
      .cs  (cs),
      .dout(outp[k*SLICE_W +: SLICE_W])
    );
  end
endmodule

// File: tb/tb_sram_h_cascading.sv
// Directed bench for the cascaded SRAM.
// Inputs change on the falling edge; outputs sampled 1ns after rising.
module tb_sram_h_cascading;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  sram_h_cascading_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  sram_h_cascading dut (
    .clk (clk),
    .rst (rst),
    .inp (bus.inp),
    .addr(bus.addr),
    .we  (bus.we),
    .cs  (bus.cs),
    .outp(bus.outp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] sweep [8] = '{8'h24, 8'h81, 8'h09, 8'h63,
                            8'h0D, 8'h8D, 8'h65, 8'h12};

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1;
    bus.addr = a; bus.inp = d;
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(posedge clk);
    #1;
    v = bus.outp;
    bus.cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.outp !== 8'h00) begin
      bad++;
      $display("FAIL reset_outp got=%h want=00", bus.outp);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      total++;
      if (v !== 8'h00) begin
        bad++;
        $display("FAIL reset_read a=%0d got=%h want=00", i, v);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) wr(3'(i), sweep[i]);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      total++;
      if (v !== sweep[i]) begin
        bad++;
        $display("FAIL sweep a=%0d got=%h want=%h", i, v, sweep[i]);
      end
    end
  endtask

  task automatic test_slices();
    logic [7:0] v;
    wr(3'd2, 8'hF0);
    wr(3'd5, 8'h0F);
    rd(3'd2, v);
    total++;
    if (v !== 8'hF0) begin
      bad++;
      $display("FAIL slice_hi got=%h want=F0", v);
    end
    rd(3'd5, v);
    total++;
    if (v !== 8'h0F) begin
      bad++;
      $display("FAIL slice_lo got=%h want=0F", v);
    end
  endtask

  task automatic test_deselect();
    logic [7:0] v;
    rd(3'd6, v);
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b1;
    bus.addr = 3'd0; bus.inp = 8'hAA;
    repeat (3) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.outp !== 8'h65) begin
        bad++;
        $display("FAIL desel_hold got=%h want=65", bus.outp);
      end
    end
    bus.we = 1'b0;
    rd(3'd0, v);
    total++;
    if (v !== 8'h24) begin
      bad++;
      $display("FAIL desel_mem got=%h want=24", v);
    end
  endtask

  task automatic test_overwrite();
    logic [7:0] v;
    wr(3'd7, 8'h11);
    wr(3'd7, 8'h22);
    rd(3'd7, v);
    total++;
    if (v !== 8'h22) begin
      bad++;
      $display("FAIL overwrite got=%h want=22", v);
    end
    wr(3'd3, 8'h33);
    total++;
    if (bus.outp !== 8'h22) begin
      bad++;
      $display("FAIL write_hold got=%h want=22", bus.outp);
    end
    rd(3'd3, v);
    total++;
    if (v !== 8'h33) begin
      bad++;
      $display("FAIL wr_then_rd got=%h want=33", v);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] v;
    for (int i = 0; i < 3; i++) wr(3'(i), 8'h5A);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1;
    bus.addr = 3'd3; bus.inp = 8'hC3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.outp !== 8'h00) begin
      bad++;
      $display("FAIL midrst_outp got=%h want=00", bus.outp);
    end
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      total++;
      if (v !== 8'h00) begin
        bad++;
        $display("FAIL midrst_read a=%0d got=%h want=00", i, v);
      end
    end
    wr(3'd4, 8'h7E);
    rd(3'd4, v);
    total++;
    if (v !== 8'h7E) begin
      bad++;
      $display("FAIL post_rst_wr got=%h want=7E", v);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    bus.cs = 1'b0; bus.we = 1'b0;
    bus.addr = '0; bus.inp = '0;
    test_reset();
    test_sweep();
    test_slices();
    test_deselect();
    test_overwrite();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
